// File: rtl/ul8_mem_pkg.sv
// Shared defaults and FSM state type for the ul8 memory access blocks.
package ul8_mem_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP,
    CLEAR
  } state_t;

endpackage

// File: rtl/ram_access_ctrl.sv
// Single-outstanding CPU-to-RAM access controller with fixed load/store latency.
// Optional zero-fill of the whole RAM is compiled in with RAM_ACCESS_CTRL_CLEAR_EN.
module ram_access_ctrl
  import ul8_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_value_in,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_value_out,
  input  logic              clear_start,
  output logic              clear_busy
);

  state_t state;

`ifdef RAM_ACCESS_CTRL_CLEAR_EN
  assign req_ready = (state == IDLE) && !clear_start;
`else
  logic unused_clear_start;
  assign unused_clear_start = clear_start;
  assign req_ready  = (state == IDLE);
  assign clear_busy = 1'b0;
`endif

  // The RAM port registers double as the latched request; ram_address is also
  // the zero-fill counter, so CLEAR needs no extra state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      ram_address  <= '0;
      ram_value_in <= '0;
      ram_write    <= 1'b0;
`ifdef RAM_ACCESS_CTRL_CLEAR_EN
      clear_busy   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef RAM_ACCESS_CTRL_CLEAR_EN
          if (clear_start) begin
            state        <= CLEAR;
            clear_busy   <= 1'b1;
            ram_address  <= '0;
            ram_value_in <= '0;
            ram_write    <= 1'b1;
          end else
`endif
          if (req_valid) begin
            state        <= ISSUE;
            ram_address  <= req_addr;
            ram_value_in <= req_wdata;
            ram_write    <= req_write;
          end
        end
        ISSUE: begin
          ram_write <= 1'b0;
          state     <= CAPTURE;
        end
        CAPTURE: begin
          rsp_rdata <= ram_value_out;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
`ifdef RAM_ACCESS_CTRL_CLEAR_EN
        CLEAR: begin
          if (ram_address == '1) begin
            ram_write  <= 1'b0;
            clear_busy <= 1'b0;
            state      <= IDLE;
          end else begin
            ram_address <= ram_address + 1'b1;
          end
        end
`endif
        default: begin
          ram_write <= 1'b0;
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard bench for ram_access_ctrl with a registered-read RAM model.
// Exercises zero-fill only when RAM_ACCESS_CTRL_CLEAR_EN is defined.
module tb_ram_access_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_write, req_ready;
  logic [4:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata;
  logic [4:0] ram_address;
  logic [7:0] ram_value_in, ram_value_out;
  logic       ram_write;
  logic       clear_start, clear_busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] ram_mem [32];
  logic [7:0] ref_mem [32];
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  ram_access_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .ram_address  (ram_address),
    .ram_value_in (ram_value_in),
    .ram_write    (ram_write),
    .ram_value_out(ram_value_out),
    .clear_start  (clear_start),
    .clear_busy   (clear_busy)
  );

  // RAM model: read data registered on the address-sampling edge, write data echoed.
  always @(posedge clk) begin
    if (ram_write) ram_mem[ram_address] <= ram_value_in;
    ram_value_out <= ram_write ? ram_value_in : ram_mem[ram_address];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [4:0] addr, input logic [7:0] wdata, input int hold);
    logic [7:0] got_exp;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    rsp_ready = (hold == 0);
    #1 checkOutput("req_ready_idle", {31'd0, req_ready}, 32'd1);
    exp_q.push_back(wr ? wdata : ref_mem[addr]);
    if (wr) ref_mem[addr] = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checkOutput("issue_ram_write", {31'd0, ram_write}, {31'd0, wr});
    checkOutput("issue_ram_address", {27'd0, ram_address}, {27'd0, addr});
    if (wr) checkOutput("issue_ram_value_in", {24'd0, ram_value_in}, {24'd0, wdata});
    checkOutput("issue_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("issue_req_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("issue_clear_busy", {31'd0, clear_busy}, 32'd0);
    @(negedge clk);
    checkOutput("capture_ram_write", {31'd0, ram_write}, 32'd0);
    checkOutput("capture_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    checkOutput("resp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
      got_exp = 8'h00;
    end else begin
      got_exp = exp_q.pop_front();
    end
    checkOutput("resp_rsp_rdata", {24'd0, rsp_rdata}, {24'd0, got_exp});
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      checkOutput("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("hold_rsp_rdata", {24'd0, rsp_rdata}, {24'd0, got_exp});
      checkOutput("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    if (hold > 0) begin
      checkOutput("hold_last_req_ready", {31'd0, req_ready}, 32'd0);
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    checkOutput("done_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("done_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [4:0] a;
    logic [7:0] d;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b1; clear_start = 1'b0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;

    #12;
    checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("reset_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    checkOutput("reset_ram_address", {27'd0, ram_address}, 32'd0);
    checkOutput("reset_ram_value_in", {24'd0, ram_value_in}, 32'd0);
    checkOutput("reset_ram_write", {31'd0, ram_write}, 32'd0);
    checkOutput("reset_clear_busy", {31'd0, clear_busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b1, 5'd5, 8'hA7, 0);
    applyStimulus(1'b0, 5'd5, 8'h00, 0);
    applyStimulus(1'b0, 5'd5, 8'h00, 4);

    for (int n = 0; n < 3; n++) begin
      a = 5'(16 + n * 5);
      d = 8'($urandom_range(0, 255));
      applyStimulus(1'b1, a, d, int'($urandom_range(0, 2)));
      applyStimulus(1'b0, a, 8'h00, int'($urandom_range(0, 2)));
    end

`ifdef RAM_ACCESS_CTRL_CLEAR_EN
    @(negedge clk);
    clear_start = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd7; req_wdata = 8'h55;
    #1 checkOutput("clear_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1 clear_start = 1'b0;
    req_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      checkOutput("clear_busy_on", {31'd0, clear_busy}, 32'd1);
      checkOutput("clear_ram_write", {31'd0, ram_write}, 32'd1);
      checkOutput("clear_ram_address", {27'd0, ram_address}, i);
      checkOutput("clear_ram_value_in", {24'd0, ram_value_in}, 32'd0);
    end
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
    @(negedge clk);
    checkOutput("clear_busy_off", {31'd0, clear_busy}, 32'd0);
    checkOutput("clear_end_ram_write", {31'd0, ram_write}, 32'd0);
    checkOutput("clear_end_req_ready", {31'd0, req_ready}, 32'd1);
    applyStimulus(1'b0, 5'd5, 8'h00, 0);
    applyStimulus(1'b0, 5'd7, 8'h00, 0);
`else
    clear_start = 1'b1;
    applyStimulus(1'b1, 5'd9, 8'h3E, 0);
    checkOutput("noclear_busy", {31'd0, clear_busy}, 32'd0);
    clear_start = 1'b0;
    applyStimulus(1'b0, 5'd9, 8'h00, 0);
`endif

    // Reset during the ISSUE cycle of a store.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd12; req_wdata = 8'h3C;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_issue_ram_write", {31'd0, ram_write}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_ram_write_drop", {31'd0, ram_write}, 32'd0);
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_ram_address", {27'd0, ram_address}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_after_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      checkOutput("rst_after_req_ready", {31'd0, req_ready}, 32'd1);
      checkOutput("rst_after_ram_write", {31'd0, ram_write}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
